// File: rtl/mac_select_pipe_if.sv
// ----------------------------------------------------------------------------
// mac_select_pipe_if : beat-in / result-out handshake bundle for mac_select_pipe
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mac_select_pipe_if #(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int SEL_W  = 2,
  parameter int OUT_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NCH*DATA_W-1:0]   a_bus;
  logic [NCH*DATA_W-1:0]   k_bus;
  logic                    first;
  logic                    last;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_sat;

  modport master (
    output in_valid, sel, a_bus, k_bus, first, last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, sel, a_bus, k_bus, first, last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/mac_select_pipe.sv
// ----------------------------------------------------------------------------
// mac_select_pipe : select one (a,k) pair per beat, multiply, window-accumulate,
//                   round-shift and saturate. Two register stages, one stall.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_select_pipe #(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int SEL_W  = 2,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 1,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  mac_select_pipe_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  // Two guard bits: one for the sign of unsigned sums, one for the rounding carry.
  localparam int RND_W  = ACC_W + 2;

  localparam logic signed [RND_W-1:0] c_half =
    (SHIFT > 0) ? (RND_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RND_W-1:0] c_max =
    RND_W'((SIGNED != 0) ? ((64'sd1 <<< (OUT_W - 1)) - 64'sd1)
                         : ((64'sd1 <<< OUT_W) - 64'sd1));
  localparam logic signed [RND_W-1:0] c_min =
    RND_W'((SIGNED != 0) ? -(64'sd1 <<< (OUT_W - 1)) : 64'sd0);

  logic                     out_valid_q;
  logic [OUT_W-1:0]         out_data_q;
  logic                     out_sat_q;
  logic                     s1_valid_q;
  logic [PROD_W-1:0]        s1_prod_q;
  logic                     s1_first_q;
  logic                     s1_last_q;
  logic [ACC_W-1:0]         acc_q;

  logic                     w_en;
  logic                     w_accept;
  logic [DATA_W-1:0]        w_a_sel;
  logic [DATA_W-1:0]        w_k_sel;
  logic [PROD_W-1:0]        w_a_ext;
  logic [PROD_W-1:0]        w_k_ext;
  logic [PROD_W-1:0]        w_prod;
  logic [ACC_W-1:0]         w_prod_ext;
  logic [ACC_W-1:0]         w_sum;
  logic signed [RND_W-1:0]  w_sum_x;
  logic signed [RND_W-1:0]  w_rnd;
  logic signed [RND_W-1:0]  w_r;
  logic [OUT_W-1:0]         out_data_d;
  logic                     out_sat_d;

  // A held result freezes every stage, so nothing upstream may advance.
  assign w_en         = ~out_valid_q | bus.out_ready;
  assign w_accept     = bus.in_valid & w_en;
  assign bus.in_ready = w_en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  always_comb begin
    w_a_sel = '0;
    w_k_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.sel == SEL_W'(i + 1)) begin
        w_a_sel = bus.a_bus[i*DATA_W +: DATA_W];
        w_k_sel = bus.k_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  // Low PROD_W bits of the extended operands' product are exact in both modes.
  assign w_a_ext = (SIGNED != 0) ? PROD_W'($signed(w_a_sel)) : PROD_W'(w_a_sel);
  assign w_k_ext = (SIGNED != 0) ? PROD_W'($signed(w_k_sel)) : PROD_W'(w_k_sel);
  assign w_prod  = w_a_ext * w_k_ext;

  assign w_prod_ext = (SIGNED != 0) ? ACC_W'($signed(s1_prod_q)) : ACC_W'(s1_prod_q);
  assign w_sum      = (s1_first_q ? '0 : acc_q) + w_prod_ext;
  assign w_sum_x    = (SIGNED != 0) ? RND_W'($signed(w_sum)) : RND_W'(w_sum);
  assign w_rnd      = w_sum_x + c_half;
  assign w_r        = w_rnd >>> SHIFT;

  always_comb begin
    out_data_d = w_r[OUT_W-1:0];
    out_sat_d  = 1'b0;
    if (w_r > c_max) begin
      out_data_d = c_max[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end else if (w_r < c_min) begin
      out_data_d = c_min[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (w_en) begin
      s1_valid_q <= w_accept;
      s1_prod_q  <= w_prod;
      s1_first_q <= bus.first;
      s1_last_q  <= bus.last;
      if (s1_valid_q) begin
        acc_q <= w_sum;
      end
      if (s1_valid_q && s1_last_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_sat_q   <= out_sat_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_select_pipe.sv
// ----------------------------------------------------------------------------
// tb_mac_select_pipe : scoreboard bench, unsigned and signed instances side by side
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mac_select_pipe;

  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int SW  = 2;
  localparam int AW  = 24;
  localparam int OW  = 8;
  localparam int SH  = 1;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_select_pipe_if #(.DATA_W(DW), .NCH(NCH), .SEL_W(SW), .OUT_W(OW)) bu ();
  mac_select_pipe_if #(.DATA_W(DW), .NCH(NCH), .SEL_W(SW), .OUT_W(OW)) bs ();

  mac_select_pipe #(.DATA_W(DW), .NCH(NCH), .SEL_W(SW), .ACC_W(AW), .OUT_W(OW),
                    .SHIFT(SH), .SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(bu));
  mac_select_pipe #(.DATA_W(DW), .NCH(NCH), .SEL_W(SW), .ACC_W(AW), .OUT_W(OW),
                    .SHIFT(SH), .SIGNED(1)) u_dut_s (.clk(clk), .rst(rst), .bus(bs));

  exp_t       q_u[$];
  exp_t       q_s[$];
  longint     acc_raw[2];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         rand_bp = 0;
  bit         stall_arm = 0;
  int         stall_cnt = 0;
  bit         prev_stall[2];
  logic [7:0] prev_d[2];
  logic       prev_s[2];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: window sum in plain integers, wrapped to AW bits, then rounded and clipped.
  task automatic send(input int d, input int sel, input logic [23:0] a, input logic [23:0] k,
                      input bit f, input bit l, input bit use_exp, input int exp_d, input bit exp_s);
    longint pa, pk, val, r, c, lo, hi;
    logic [7:0] ab, kb;
    exp_t e;
    int n;
    pa = 0;
    pk = 0;
    if (sel >= 1 && sel <= NCH) begin
      ab = a[(sel-1)*8 +: 8];
      kb = k[(sel-1)*8 +: 8];
      pa = (d != 0) ? longint'($signed(ab)) : longint'(ab);
      pk = (d != 0) ? longint'($signed(kb)) : longint'(kb);
    end
    acc_raw[d] = ((f ? 64'sd0 : acc_raw[d]) + pa * pk) & 64'hFFFFFF;
    val = (d != 0 && acc_raw[d] >= 64'h800000) ? acc_raw[d] - 64'h1000000 : acc_raw[d];
    r   = (val + (64'sd1 <<< (SH - 1))) >>> SH;
    lo  = (d != 0) ? -128 : 0;
    hi  = (d != 0) ? 127 : 255;
    c   = (r < lo) ? lo : ((r > hi) ? hi : r);
    e.d = 8'(c);
    e.s = (c != r);
    if (use_exp) begin
      e.d = exp_d[7:0];
      e.s = exp_s;
    end
    if (l) begin
      if (d == 0) q_u.push_back(e);
      else        q_s.push_back(e);
    end

    @(negedge clk);
    if (d == 0) begin
      bu.sel = SW'(sel); bu.a_bus = a; bu.k_bus = k; bu.first = f; bu.last = l; bu.in_valid = 1'b1;
    end else begin
      bs.sel = SW'(sel); bs.a_bus = a; bs.k_bus = k; bs.first = f; bs.last = l; bs.in_valid = 1'b1;
    end
    #2;
    n = 0;
    while (!((d == 0) ? bu.in_ready : bs.in_ready)) begin
      if (n == 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, required 1", n);
        break;
      end
      @(negedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #1;
    bu.in_valid = 1'b0;
    bs.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q_u.delete();
    q_s.delete();
    acc_raw[0] = 0;
    acc_raw[1] = 0;
    #1;
    chk("rst_valid_u", bu.out_valid, 0);
    chk("rst_data_u",  bu.out_data,  0);
    chk("rst_sat_u",   bu.out_sat,   0);
    chk("rst_valid_s", bs.out_valid, 0);
    chk("rst_data_s",  bs.out_data,  0);
    chk("rst_sat_s",   bs.out_sat,   0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q_u.size() != 0 || q_s.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d results outstanding, required 0/0", q_u.size(), q_s.size());
    end
  endtask

  task automatic mon(input int d, input logic ov, input logic ordy, input logic irdy,
                     input logic [7:0] od, input logic os);
    exp_t e;
    if (rst) begin
      prev_stall[d] = 1'b0;
      return;
    end
    if (prev_stall[d]) begin
      chk("hold_valid", ov, 1);
      chk("hold_data", od, prev_d[d]);
      chk("hold_sat", os, prev_s[d]);
    end
    if (ov && !ordy) begin
      chk("stall_in_ready", irdy, 0);
      prev_stall[d] = 1'b1;
      prev_d[d]     = od;
      prev_s[d]     = os;
    end else begin
      prev_stall[d] = 1'b0;
    end
    if (ov && ordy) begin
      if ((d == 0) ? (q_u.size() == 0) : (q_s.size() == 0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output dut%0d: got data %0d, required no result", d, od);
      end else begin
        e = (d == 0) ? q_u.pop_front() : q_s.pop_front();
        chk((d == 0) ? "out_data_u" : "out_data_s", od, e.d);
        chk((d == 0) ? "out_sat_u"  : "out_sat_s",  os, e.s);
      end
    end
  endtask

  always @(negedge clk) begin
    logic ro;
    if (stall_arm && (bu.out_valid || bs.out_valid)) begin
      stall_cnt = 3;
      stall_arm = 0;
    end
    if (stall_cnt > 0) begin
      ro = 1'b0;
      stall_cnt--;
    end else begin
      ro = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    bu.out_ready = ro;
    bs.out_ready = ro;
  end

  always @(negedge clk) begin
    #1;
    mon(0, bu.out_valid, bu.out_ready, bu.in_ready, bu.out_data, bu.out_sat);
    mon(1, bs.out_valid, bs.out_ready, bs.in_ready, bs.out_data, bs.out_sat);
  end

  initial begin
    logic [23:0] ra, rk, m;
    bu.in_valid = 0; bu.sel = '0; bu.a_bus = '0; bu.k_bus = '0; bu.first = 0; bu.last = 0;
    bs.in_valid = 0; bs.sel = '0; bs.a_bus = '0; bs.k_bus = '0; bs.first = 0; bs.last = 0;
    bu.out_ready = 1; bs.out_ready = 1;
    prev_stall[0] = 0; prev_stall[1] = 0;

    do_reset();
    #3;
    chk("in_ready_after_rst_u", bu.in_ready, 1);
    chk("in_ready_after_rst_s", bs.in_ready, 1);

    // Single beat: result visible two edges after the handshake cycle.
    send(0, 1, 24'h00000A, 24'h000006, 1, 1, 1, 30, 0);
    @(negedge clk); #1;
    chk("latency_edge1", bu.out_valid, 0);
    @(negedge clk); #1;
    chk("latency_edge2", bu.out_valid, 1);

    send(0, 1, {8'd2, 8'd10, 8'd10}, {8'd2, 8'd10, 8'd6}, 1, 0, 0, 0, 0);
    send(0, 2, {8'd2, 8'd10, 8'd10}, {8'd2, 8'd10, 8'd6}, 0, 0, 0, 0, 0);
    send(0, 3, {8'd2, 8'd10, 8'd10}, {8'd2, 8'd10, 8'd6}, 0, 1, 1, 82, 0);
    send(0, 1, 24'h000007, 24'h000001, 1, 1, 1, 4, 0);
    send(0, 1, 24'h0000FF, 24'h0000FF, 1, 1, 1, 255, 1);
    send(0, 0, 24'hFFFFFF, 24'hFFFFFF, 1, 1, 1, 0, 0);
    drain();

    stall_arm = 1;
    for (int i = 0; i < 6; i++) begin
      send(0, (i % 3) + 1, $urandom & 24'h1F1F1F, $urandom & 24'h0F0F0F, 1, 1, 0, 0, 0);
    end
    drain();

    send(1, 1, 24'h0000FC, 24'h000003, 1, 1, 1, 8'hFA, 0);
    send(1, 1, 24'h000080, 24'h000080, 1, 1, 1, 8'h7F, 1);
    drain();

    send(0, 1, 24'h000005, 24'h000005, 1, 0, 0, 0, 0);
    send(0, 1, 24'h000005, 24'h000005, 0, 0, 0, 0, 0);
    do_reset();
    send(0, 1, 24'h000002, 24'h000004, 0, 1, 1, 4, 0);
    send(0, 1, 24'h000002, 24'h000004, 1, 1, 1, 4, 0);
    drain();

    rand_bp = 1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) begin
        case ($urandom_range(0, 2))
          0:       m = 24'hFFFFFF;
          1:       m = 24'h0F0F0F;
          default: m = 24'h030303;
        endcase
        ra = $urandom & m;
        rk = $urandom & m;
        send(d, $urandom_range(0, 3), ra, rk, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, 0, 0, 0);
      end
      drain();
    end
    rand_bp = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
